ram_bus_arbiter: RTL
====================

Name: ram_bus_arbiter

Overview:
- Shares the single data_ram port between two requesters: M0 (CPU load/store port) and M1 (DMA/debug loader).
- Sits in the SoC top between the openmips data-memory port, the secondary master and data_ram.
- Round-robin arbitration with a registered grant and a hold-limit anti-starvation counter.
- Exposes a per-master ack so each requester can stall until its access is performed.

Parameters:
- MAX_HOLD, 8: max consecutive granted cycles for one master while the other is requesting; range 1..255.
- HOLD_W, 8: width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock.
- rst  in  reset_status_t  asynchronous, active-low reset (asserted value 1'b0).
- m0_ce_i / m1_ce_i  in  chip_status_t  request/enable from M0 / M1.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_sel_i / m1_sel_i  in  4  byte lane select.
- m0_addr_i / m1_addr_i  in  ram_addr_t  address.
- m0_data_i / m1_data_i  in  ram_data_t  write data.
- m0_data_o / m1_data_o  out  ram_data_t  read data.
- m0_ack_o / m1_ack_o  out  1  access performed this cycle.
- ram_ce_o  out  chip_status_t  to data_ram ce.
- ram_we_o  out  1  to data_ram we.
- ram_sel_o  out  4  to data_ram sel.
- ram_addr_o  out  ram_addr_t  to data_ram addr.
- ram_data_o  out  ram_data_t  to data_ram data_i.
- ram_data_i  in  ram_data_t  from data_ram data_o.

Behaviour:
- Grant register gnt with states IDLE, OWN_M0, OWN_M1; last-winner pointer rr (reset value M1, so M0 wins the first tie); hold counter hold_cnt.
- Reset (async, rst==0):
  - gnt=IDLE, rr=M1, hold_cnt=0.
  - Outputs: ram_ce_o=disabled, ram_we_o=0, ram_sel_o=0, ram_addr_o=0, ram_data_o=0, both ack=0, both data_o=0.
- Output mux is combinational from gnt:
  - IDLE: RAM outputs zero/disabled.
  - OWN_Mx: RAM outputs driven from Mx's inputs.
- Ack and read data:
  - mx_ack_o = (gnt==OWN_Mx) && mx_ce_i enabled.
  - mx_data_o = ram_data_i when mx_ack_o is high, else 0.
  - Reads are combinational in the ack cycle; writes commit at the clock edge ending the ack cycle.
- Latency: a request raised in cycle n from IDLE is granted at the edge ending cycle n and acked in cycle n+1; each access takes exactly one cycle.
- A master keeps ce/we/sel/addr/data stable until it sees ack; after ack it may issue a new access back-to-back.
- Next-state rules (evaluated every edge):
  - IDLE, single request: grant it.
  - IDLE, both requesting: grant the master != rr.
  - IDLE, no request: stay IDLE.
  - OWN_Mx, Mx still requesting, other idle: keep; hold_cnt=0.
  - OWN_Mx, Mx still requesting, other requesting:
    - if hold_cnt == MAX_HOLD-1: switch to other, hold_cnt=0;
    - else keep, hold_cnt++.
  - OWN_Mx, Mx drops ce: grant the other if it is requesting, else IDLE; hold_cnt=0.
- rr updates to Mx on every transition into OWN_Mx.
- Bubble-free handover: the switching edge ends the last ack of the old owner; the new owner's ack is in the next cycle.
- A request withdrawn before ack is legal: no RAM access occurs, and the master is not acked.
- hold_cnt saturates and never wraps.
- Reset mid-access: any uncommitted write is dropped; the state machine restarts in IDLE.

Optional Feature:
- ARB_STATS_EN defined: adds outputs m0_grants_o[31:0], m1_grants_o[31:0], conflict_o[31:0].
  - mx_grants_o counts acked cycles per master.
  - conflict_o counts cycles where both ce are enabled.
  - All three wrap modulo 2^32, clear on reset, and add no latency.
- ARB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package project_types holds:
  - arb_grant_t enum {ARB_IDLE, ARB_M0, ARB_M1};
  - ARB_MAX_HOLD_DEFAULT constant;
  - reuse of chip_status_t, ram_addr_t, ram_data_t, reset_status_t.
- One sub-module: arb_stats_counter (32-bit wrapping enable counter), instantiated three times under ARB_STATS_EN.

Test Plan:
- Reset then M0 write addr 0x10, data 0xDEADBEEF, sel 4'hF -> ack in the cycle after the request; a later M0 read of 0x10 returns 0xDEADBEEF on m0_data_o; m1_data_o=0.
- Both request from IDLE after reset -> M0 acked first; a following simultaneous new request -> M1 granted (round-robin).
- M0 requests continuously with MAX_HOLD=4 while M1 also requests -> M0 acked 4 cycles, M1 acked in cycle 5, no idle gap.
- M1 raises ce, drops it before grant -> no RAM access, no ack, gnt returns IDLE.
- Async rst=0 pulse mid-write (between clock edges) -> all outputs zero immediately; target word unchanged; first post-reset request acked after 1 cycle.
- ARB_STATS_EN: 10 overlapping requests -> conflict_o and grant counts match the scoreboard.

Source files
------------

// File: rtl/ram_bus_arbiter_pkg.sv
// rtl/ram_bus_arbiter_pkg.sv - shared types and constants for the data_ram bus arbiter
//
// Package project_types:
//   reset_status_t / RST_ENABLE      reset signal type and its asserted (active-low) value
//   chip_status_t / CHIP_ENABLE/...  chip-enable type and its two levels
//   ram_addr_t / ram_data_t          data_ram address and data words
//   arb_grant_t                      registered grant owner (idle, M0, M1)
//   arb_master_t                     round-robin last-winner pointer
//   ARB_MAX_HOLD_DEFAULT             default contested-hold limit
//   ARB_HOLD_W_DEFAULT               default hold counter width

package project_types;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE  = 1'b0;
  localparam reset_status_t RST_DISABLE = 1'b1;

  typedef logic chip_status_t;
  localparam chip_status_t CHIP_ENABLE  = 1'b1;
  localparam chip_status_t CHIP_DISABLE = 1'b0;

  typedef logic [31:0] ram_addr_t;
  typedef logic [31:0] ram_data_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_grant_t;

  typedef enum logic {
    RR_M0 = 1'b0,
    RR_M1 = 1'b1
  } arb_master_t;

  localparam int ARB_MAX_HOLD_DEFAULT = 8;
  localparam int ARB_HOLD_W_DEFAULT   = 8;

endpackage

// File: rtl/ram_bus_arbiter_stats.sv
// rtl/ram_bus_arbiter_stats.sv - 32-bit wrapping enable counter for arbiter statistics
//
// Module arb_stats_counter:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset, clears count
//   en     in   count this cycle (sampled at the rising edge)
//   count  out  running total, wraps modulo 2^32

module arb_stats_counter
  import project_types::*;
(
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          en,
  output logic [31:0]   count
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - round-robin arbiter sharing the data_ram port between M0 and M1
//
// Optional build macro: ARB_STATS_EN adds the grant/conflict statistics counters.
//
// Ports:
//   clk                  in   system clock
//   rst                  in   asynchronous active-low reset
//   m0_/m1_ce_i          in   request (chip enable) from each master
//   m0_/m1_we_i          in   write enable
//   m0_/m1_sel_i         in   byte lane select
//   m0_/m1_addr_i        in   address
//   m0_/m1_data_i        in   write data
//   m0_/m1_data_o        out  read data, zero unless that master is acked
//   m0_/m1_ack_o         out  access performed this cycle
//   ram_ce_o .. ram_data_o  out  data_ram port, driven from the grant owner
//   ram_data_i           in   data_ram read data
//   m0_/m1_grants_o      out  acked cycles per master      (ARB_STATS_EN only)
//   conflict_o           out  cycles with both ce enabled  (ARB_STATS_EN only)

module ram_bus_arbiter
  import project_types::*;
#(
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
  parameter int HOLD_W   = ARB_HOLD_W_DEFAULT
) (
  input  logic          clk,
  input  reset_status_t rst,

  input  chip_status_t  m0_ce_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  ram_addr_t     m0_addr_i,
  input  ram_data_t     m0_data_i,
  output ram_data_t     m0_data_o,
  output logic          m0_ack_o,

  input  chip_status_t  m1_ce_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  ram_addr_t     m1_addr_i,
  input  ram_data_t     m1_data_i,
  output ram_data_t     m1_data_o,
  output logic          m1_ack_o,

  output chip_status_t  ram_ce_o,
  output logic          ram_we_o,
  output logic [3:0]    ram_sel_o,
  output ram_addr_t     ram_addr_o,
  output ram_data_t     ram_data_o,
  input  ram_data_t     ram_data_i
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   m0_grants_o,
  output logic [31:0]   m1_grants_o,
  output logic [31:0]   conflict_o
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

  arb_grant_t        gnt, gnt_nxt;
  arb_master_t       rr, rr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic       m0_req, m1_req;
  logic       cur_req, oth_req;
  arb_grant_t oth_gnt;

  assign m0_req = (m0_ce_i == CHIP_ENABLE);
  assign m1_req = (m1_ce_i == CHIP_ENABLE);

  // Grant register, round-robin pointer and contested-hold counter.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      gnt      <= ARB_IDLE;
      rr       <= RR_M1;
      hold_cnt <= '0;
    end else begin
      gnt      <= gnt_nxt;
      rr       <= rr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Express the current owner's view as "own request" / "other request" so
  // one set of rules serves both OWN_M0 and OWN_M1.
  always_comb begin
    cur_req = 1'b0;
    oth_req = 1'b0;
    oth_gnt = ARB_IDLE;
    case (gnt)
      ARB_M0: begin
        cur_req = m0_req;
        oth_req = m1_req;
        oth_gnt = ARB_M1;
      end
      ARB_M1: begin
        cur_req = m1_req;
        oth_req = m0_req;
        oth_gnt = ARB_M0;
      end
      default: begin
        cur_req = 1'b0;
        oth_req = 1'b0;
        oth_gnt = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_nxt  = gnt;
    rr_nxt   = rr;
    hold_nxt = hold_cnt;

    case (gnt)
      ARB_M0, ARB_M1: begin
        if (cur_req && oth_req) begin
          // Contested: the owner may keep the port for MAX_HOLD cycles in a row.
          if (hold_cnt == HOLD_LAST) begin
            gnt_nxt  = oth_gnt;
            hold_nxt = '0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end else if (cur_req) begin
          hold_nxt = '0;
        end else begin
          // Owner released (or withdrew) its request: hand over without a bubble.
          hold_nxt = '0;
          gnt_nxt  = oth_req ? oth_gnt : ARB_IDLE;
        end
      end
      default: begin
        hold_nxt = '0;
        if (m0_req && m1_req) begin
          // Tie from idle goes to whichever master did not win last.
          gnt_nxt = (rr == RR_M0) ? ARB_M1 : ARB_M0;
        end else if (m0_req) begin
          gnt_nxt = ARB_M0;
        end else if (m1_req) begin
          gnt_nxt = ARB_M1;
        end else begin
          gnt_nxt = ARB_IDLE;
        end
      end
    endcase

    if (gnt_nxt == ARB_M0 && gnt != ARB_M0) begin
      rr_nxt = RR_M0;
    end else if (gnt_nxt == ARB_M1 && gnt != ARB_M1) begin
      rr_nxt = RR_M1;
    end
  end

  // RAM port follows the registered owner; the owner's own ce passes through,
  // so a request withdrawn while owned never reaches the RAM.
  always_comb begin
    ram_ce_o   = CHIP_DISABLE;
    ram_we_o   = 1'b0;
    ram_sel_o  = 4'h0;
    ram_addr_o = '0;
    ram_data_o = '0;
    case (gnt)
      ARB_M0: begin
        ram_ce_o   = m0_ce_i;
        ram_we_o   = m0_we_i;
        ram_sel_o  = m0_sel_i;
        ram_addr_o = m0_addr_i;
        ram_data_o = m0_data_i;
      end
      ARB_M1: begin
        ram_ce_o   = m1_ce_i;
        ram_we_o   = m1_we_i;
        ram_sel_o  = m1_sel_i;
        ram_addr_o = m1_addr_i;
        ram_data_o = m1_data_i;
      end
      default: begin
        ram_ce_o = CHIP_DISABLE;
      end
    endcase
  end

  assign m0_ack_o  = (gnt == ARB_M0) && m0_req;
  assign m1_ack_o  = (gnt == ARB_M1) && m1_req;
  assign m0_data_o = m0_ack_o ? ram_data_i : '0;
  assign m1_data_o = m1_ack_o ? ram_data_i : '0;

`ifdef ARB_STATS_EN
  logic both_req;
  assign both_req = m0_req && m1_req;

  arb_stats_counter u_m0_grants (
    .clk   (clk),
    .rst   (rst),
    .en    (m0_ack_o),
    .count (m0_grants_o)
  );

  arb_stats_counter u_m1_grants (
    .clk   (clk),
    .rst   (rst),
    .en    (m1_ack_o),
    .count (m1_grants_o)
  );

  arb_stats_counter u_conflicts (
    .clk   (clk),
    .rst   (rst),
    .en    (both_req),
    .count (conflict_o)
  );
`endif

endmodule
